motion_alarm_ctrl: RTL

MOTION_ALARM_CTRL -- requirements
Module: motion_alarm_ctrl

---
 rtl/motion_alarm_ctrl.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/motion_alarm_ctrl.sv
// motion_alarm_ctrl
// Three-zone PIR motion alarm controller. Each zone's sensor output is compared
// against a threshold and debounced. A qualified detection while the system is
// armed raises a latched alarm and records which zones triggered. An exit delay
// (ARMING) runs before detection is enabled, both after arming and after each
// alarm acknowledge. A saturating counter records how many alarms occurred.

module motion_alarm_ctrl #(
    parameter logic [6:0]  THRESHOLD = 7'd20, // a sample strictly above this is a hit
    parameter int unsigned DEBOUNCE  = 4,     // consecutive hits needed, 1..15
    parameter int unsigned ARM_DELAY = 8      // cycles spent in ARMING, 1..255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       turn,
    input  logic       stop_alarm,
    input  logic [6:0] pir_sensor_1,
    input  logic [6:0] pir_sensor_2,
    input  logic [6:0] pir_sensor_3,
    output logic       alarm,
    output logic       armed,
    output logic [2:0] zone,
    output logic [7:0] event_count,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        DISARMED = 2'd0,
        ARMING   = 2'd1,
        ARMED    = 2'd2,
        ALARM    = 2'd3
    } state_t;

    // Debounce counters saturate at DEBOUNCE. Detection fires on the hit that
    // arrives when the counter already shows DEBOUNCE-1, so the alarm
    // registers on the DEBOUNCE-th consecutive hit edge.
    localparam logic [3:0] DEB_SAT  = 4'(DEBOUNCE);
    localparam logic [3:0] DEB_QUAL = 4'(DEBOUNCE - 1);
    // The arm timer counts 0..ARM_DELAY-1 while in ARMING.
    localparam logic [7:0] ARM_LAST = 8'(ARM_DELAY - 1);

    state_t          cur_state;
    state_t          nxt_state;
    logic [7:0]      arm_timer;
    logic [7:0]      arm_timer_nxt;
    logic [2:0][3:0] deb_cnt;
    logic [2:0][3:0] deb_cnt_nxt;
    logic            alarm_nxt;
    logic            armed_nxt;
    logic [2:0]      zone_nxt;
    logic [7:0]      event_count_nxt;

    logic [2:0][6:0] pir_vec;
    logic [2:0]      hit;
    logic [2:0]      detect;
    logic            detect_en;

    // Bit i of every zone-indexed vector corresponds to sensor i+1.
    assign pir_vec   = {pir_sensor_3, pir_sensor_2, pir_sensor_1};
    assign detect_en = (cur_state == ARMED) || (cur_state == ALARM);
    assign state     = cur_state;

    // Per-zone threshold compare and debounce qualification.
    always_comb begin
        // NOTE: every signal driven in an always_comb gets a default first so
        // that no path leaves it unassigned, which would infer a latch.
        hit    = '0;
        detect = '0;
        for (int i = 0; i < 3; i++) begin
            hit[i]    = (pir_vec[i] > THRESHOLD);
            detect[i] = hit[i] && (deb_cnt[i] >= DEB_QUAL) && detect_en;
        end
    end

    // Consecutive-hit counters: run only while detection is enabled, cleared
    // by a miss, by disarm, and held at zero in DISARMED and ARMING.
    always_comb begin
        deb_cnt_nxt = '0;
        if (turn && detect_en) begin
            for (int i = 0; i < 3; i++) begin
                if (hit[i]) begin
                    deb_cnt_nxt[i] = (deb_cnt[i] == DEB_SAT) ? deb_cnt[i]
                                                             : deb_cnt[i] + 4'd1;
                end
            end
        end
    end

    // Next-state and next-output logic. Priority: disarm, then acknowledge,
    // then detection.
    always_comb begin
        nxt_state       = cur_state;
        arm_timer_nxt   = arm_timer;
        alarm_nxt       = alarm;
        zone_nxt        = zone;
        event_count_nxt = event_count;

        if (!turn) begin
            // event_count is deliberately kept across a disarm.
            nxt_state     = DISARMED;
            arm_timer_nxt = 8'd0;
            alarm_nxt     = 1'b0;
            zone_nxt      = 3'b000;
        end else begin
            unique case (cur_state)
                DISARMED: begin
                    nxt_state     = ARMING;
                    arm_timer_nxt = 8'd0;
                end
                ARMING: begin
                    if (arm_timer == ARM_LAST) begin
                        nxt_state = ARMED;
                    end else begin
                        arm_timer_nxt = arm_timer + 8'd1;
                    end
                end
                ARMED: begin
                    if (|detect) begin
                        nxt_state       = ALARM;
                        alarm_nxt       = 1'b1;
                        zone_nxt        = detect;
                        event_count_nxt = (event_count == 8'hFF) ? event_count
                                                                 : event_count + 8'd1;
                    end
                end
                ALARM: begin
                    if (stop_alarm) begin
                        // Acknowledge wins over a simultaneous detection.
                        nxt_state     = ARMING;
                        arm_timer_nxt = 8'd0;
                        alarm_nxt     = 1'b0;
                        zone_nxt      = 3'b000;
                    end else begin
                        zone_nxt = zone | detect;
                    end
                end
                default: begin
                    nxt_state = DISARMED;
                end
            endcase
        end

        armed_nxt = (nxt_state == ARMED) || (nxt_state == ALARM);
    end

    // State, timers, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_state   <= DISARMED;
            arm_timer   <= 8'd0;
            deb_cnt     <= '0;
            alarm       <= 1'b0;
            armed       <= 1'b0;
            zone        <= 3'b000;
            event_count <= 8'd0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values, independent of statement order.
            cur_state   <= nxt_state;
            arm_timer   <= arm_timer_nxt;
            deb_cnt     <= deb_cnt_nxt;
            alarm       <= alarm_nxt;
            armed       <= armed_nxt;
            zone        <= zone_nxt;
            event_count <= event_count_nxt;
        end
    end

endmodule
